fir_channel_scheduler: RTL
==========================

FIR_CHANNEL_SCHEDULER -- requirements
Module: fir_channel_scheduler

Interface
REQ-001 SHALL have parameter WIDTH, default 8, sample width in bits.
REQ-002 SHALL have parameter NUM_CH, default 4, number of requesting audio channels (power of two, 2..16).
REQ-003 SHALL have parameter TIMEOUT, default 40, maximum WAIT cycles before a job is abandoned (must exceed the 34-cycle FIR job time).
REQ-004 SHALL have port clk_in  input  1  sole clock; all logic on posedge.
REQ-005 SHALL have port rst_in  input  1  synchronous, active-high reset.
REQ-006 SHALL have port sample_in  input  NUM_CH*WIDTH  packed signed samples; channel i at [i*WIDTH +: WIDTH].
REQ-007 SHALL have port sample_valid_in  input  NUM_CH  per-channel one-cycle sample strobe.
REQ-008 SHALL have port fir_audio_out  output  WIDTH  signed sample driven to the FIR engine.
REQ-009 SHALL have port fir_valid_out  output  1  one-cycle job start to the FIR engine.
REQ-010 SHALL have port fir_result_in  input  WIDTH+1  signed filtered result from the engine.
REQ-011 SHALL have port fir_ready_in  input  1  engine result strobe.
REQ-012 SHALL have port filtered_out  output  WIDTH+1  signed result returned to the requester.
REQ-013 SHALL have port filtered_ch_out  output  $clog2(NUM_CH)  channel tag of filtered_out.
REQ-014 SHALL have port filtered_valid_out  output  1  one-cycle result strobe.
REQ-015 SHALL have port overrun_out  output  NUM_CH  one-cycle pulse per channel whose pending sample was overwritten.
REQ-016 SHALL have port timeout_out  output  1  one-cycle pulse when a job is abandoned.
REQ-017 SHALL have port busy_out  output  1  high in any state other than IDLE.

Function
REQ-018 SHALL latch sample_in slice i and set pending[i] on the cycle after sample_valid_in[i] is high.
REQ-019 SHALL implement FSM states IDLE, ISSUE, WAIT, EMIT.
REQ-020 IDLE: if any pending bit is set, SHALL grant round-robin starting at last_grant+1 (wrapping NUM_CH-1 -> 0), record the grant and go to ISSUE; otherwise stay in IDLE.
REQ-021 ISSUE: SHALL assert fir_valid_out for exactly one cycle with fir_audio_out = the granted channel's latched sample, clear that pending bit, zero the wait counter and go to WAIT.
REQ-022 WAIT: on fir_ready_in SHALL capture fir_result_in and go to EMIT; when the counter reaches TIMEOUT without fir_ready_in it SHALL pulse timeout_out, drop the job and go to IDLE.
REQ-023 EMIT: SHALL assert filtered_valid_out for one cycle with the captured result and the granted channel tag, then go to IDLE.
REQ-024 Latency: sample_valid_in at cycle t on an idle block SHALL give fir_valid_out at cycle t+2; fir_ready_in at cycle r SHALL give filtered_valid_out at cycle r+1.
REQ-025 fir_ready_in outside WAIT SHALL be ignored.
REQ-026 sample_valid_in[i] on the same cycle ISSUE clears pending[i] SHALL leave pending[i] set with the new sample, without an overrun pulse.
REQ-027 sample_valid_in[i] while pending[i] is set and not being cleared SHALL overwrite the sample and pulse overrun_out[i] on the following cycle.
REQ-028 Simultaneous strobes on several channels SHALL all be latched; service order follows REQ-020.
REQ-029 filtered_out, filtered_ch_out and fir_audio_out SHALL hold their last values when their strobes are low.
REQ-030 The engine SHALL be treated as a single-job black box; per-channel filter history is outside this block.

Reset
REQ-031 While rst_in is high, SHALL set state IDLE, pending 0, last_grant NUM_CH-1 (first grant is channel 0), and drive every output 0, including fir_valid_out, filtered_valid_out, overrun_out, timeout_out and busy_out.
REQ-032 Reset asserted mid-job SHALL abandon the job silently, with no timeout pulse and no late filtered_valid_out even if fir_ready_in arrives after reset.

Structure
REQ-033 The state enum (IDLE, ISSUE, WAIT, EMIT) and the default WIDTH, NUM_CH and TIMEOUT constants SHALL live in the shared package fir_pkg.
REQ-034 The round-robin grant logic SHALL be one sub-module, rr_arbiter (inputs: request vector and last grant; output: grant index and grant-valid).

Verification
REQ-035 Single channel: ch2 sample 0x10, engine returns 0x01F after 34 cycles -> fir_valid_out at t+2 with 0x10; filtered_valid_out with 0x01F, tag 2.
REQ-036 All four channels strobed in one cycle with 1, 2, 3, 4 -> issued in order ch0, ch1, ch2, ch3; four tagged results, no overrun.
REQ-037 Double strobe on ch1 (0x05, then 0x06) while ch0 is in WAIT -> overrun_out[1] pulses once; ch1 issues 0x06.
REQ-038 Engine never answers -> timeout_out pulses exactly TIMEOUT cycles after ISSUE; no filtered_valid_out; next pending channel issues.
REQ-039 rst_in for one cycle during WAIT, then fir_ready_in -> all outputs 0; no filtered_valid_out; the next grant goes to ch0.
REQ-040 Spurious fir_ready_in in IDLE -> no output change.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared types and default sizing for the FIR channel scheduler.
package fir_pkg;

    localparam int DEF_WIDTH   = 8;
    localparam int DEF_NUM_CH  = 4;
    localparam int DEF_TIMEOUT = 40;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_EMIT  = 2'd3
    } fir_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant: picks the first requesting channel after last_grant,
// wrapping from NUM_CH-1 back to 0. NUM_CH must be a power of two.
module rr_arbiter #(
    parameter int NUM_CH = 4
) (
    input  logic [NUM_CH-1:0]         req,
    input  logic [$clog2(NUM_CH)-1:0] last_grant,
    output logic [$clog2(NUM_CH)-1:0] grant,
    output logic                      grant_valid
);

    localparam int CH_W = $clog2(NUM_CH);

    // Scan last_grant+1 .. last_grant+NUM_CH; the index wraps by truncation.
    always_comb begin
        logic [CH_W-1:0] idx;
        grant       = '0;
        grant_valid = 1'b0;
        idx         = '0;
        for (int k = 1; k <= NUM_CH; k++) begin
            idx = last_grant + CH_W'(k);
            if (!grant_valid && req[idx]) begin
                grant       = idx;
                grant_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fir_channel_scheduler.sv
// Shares one FIR engine between NUM_CH audio channels. Each channel's latest
// sample waits in a pending slot; channels are served round-robin, one job at
// a time. Handshake: fir_valid_out is a one-cycle job start with the sample on
// fir_audio_out; the engine answers with a one-cycle fir_ready_in strobe and
// fir_result_in, which is accepted only while a job is outstanding (WAIT).
module fir_channel_scheduler
    import fir_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int NUM_CH  = DEF_NUM_CH,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                      clk_in,
    input  logic                      rst_in,
    input  logic [NUM_CH*WIDTH-1:0]   sample_in,
    input  logic [NUM_CH-1:0]         sample_valid_in,
    output logic [WIDTH-1:0]          fir_audio_out,
    output logic                      fir_valid_out,
    input  logic [WIDTH:0]            fir_result_in,
    input  logic                      fir_ready_in,
    output logic [WIDTH:0]            filtered_out,
    output logic [$clog2(NUM_CH)-1:0] filtered_ch_out,
    output logic                      filtered_valid_out,
    output logic [NUM_CH-1:0]         overrun_out,
    output logic                      timeout_out,
    output logic                      busy_out
);

    localparam int CH_W  = $clog2(NUM_CH);
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    fir_state_t        state, state_next;
    logic [NUM_CH-1:0] pending, clear_mask, overrun_q;
    logic [WIDTH-1:0]  samples [NUM_CH];
    logic [CH_W-1:0]   cur_ch, grant;
    logic              grant_valid;
    logic [CNT_W-1:0]  wait_cnt;
    logic [WIDTH:0]    result_q;
    logic [CH_W-1:0]   tag_q;
    logic [WIDTH-1:0]  audio_q;
    logic              timed_out;

    rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
        .req        (pending),
        .last_grant (cur_ch),
        .grant      (grant),
        .grant_valid(grant_valid)
    );

    // State register.
    always_ff @(posedge clk_in) begin
        if (rst_in) state <= ST_IDLE;
        else        state <= state_next;
    end

    // Next state, the pending-slot clear during ISSUE and the timeout strobe.
    always_comb begin
        state_next = state;
        clear_mask = '0;
        timed_out  = 1'b0;
        case (state)
            ST_IDLE:  if (grant_valid) state_next = ST_ISSUE;
            ST_ISSUE: begin
                clear_mask[cur_ch] = 1'b1;
                state_next         = ST_WAIT;
            end
            ST_WAIT: begin
                // A result on the last allowed cycle still wins over the timeout.
                if (fir_ready_in) begin
                    state_next = ST_EMIT;
                end else if (wait_cnt == CNT_LAST) begin
                    timed_out  = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            ST_EMIT:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Sample slots, grant record, wait counter and captured result.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            pending   <= '0;
            overrun_q <= '0;
            cur_ch    <= CH_W'(NUM_CH - 1);
            wait_cnt  <= '0;
            result_q  <= '0;
            tag_q     <= '0;
            audio_q   <= '0;
            for (int i = 0; i < NUM_CH; i++) samples[i] <= '0;
        end else begin
            // A new strobe on the slot being issued re-arms it without an overrun.
            pending   <= (pending & ~clear_mask) | sample_valid_in;
            overrun_q <= sample_valid_in & pending & ~clear_mask;
            for (int i = 0; i < NUM_CH; i++) begin
                if (sample_valid_in[i]) samples[i] <= sample_in[i*WIDTH +: WIDTH];
            end
            if (state == ST_IDLE && grant_valid) cur_ch <= grant;
            if (state == ST_ISSUE) begin
                wait_cnt <= '0;
                audio_q  <= samples[cur_ch];
            end else if (state == ST_WAIT) begin
                wait_cnt <= wait_cnt + CNT_W'(1);
            end
            if (state == ST_WAIT && fir_ready_in) begin
                result_q <= fir_result_in;
                tag_q    <= cur_ch;
            end
        end
    end

    // Outputs are all low while reset is held; data outputs hold between strobes.
    always_comb begin
        fir_valid_out      = 1'b0;
        fir_audio_out      = '0;
        filtered_valid_out = 1'b0;
        filtered_out       = '0;
        filtered_ch_out    = '0;
        overrun_out        = '0;
        timeout_out        = 1'b0;
        busy_out           = 1'b0;
        if (!rst_in) begin
            fir_valid_out      = (state == ST_ISSUE);
            fir_audio_out      = (state == ST_ISSUE) ? samples[cur_ch] : audio_q;
            filtered_valid_out = (state == ST_EMIT);
            filtered_out       = result_q;
            filtered_ch_out    = tag_q;
            overrun_out        = overrun_q;
            timeout_out        = timed_out;
            busy_out           = (state != ST_IDLE);
        end
    end

endmodule
